univ_shift_seq: RTL and testbench

Parametrised sequential universal shift register. It holds a WIDTH-bit word and performs load, complement, logical, arithmetic and rotate shifts by a programmable amount, one bit position per clock. A start/busy/done handshake frames each operation. It sits where the fixed 4-bit shifter datapath sat, as the register-plus-process stage fed by the input/feedback select.

---
 rtl/shifter_pkg.sv | 26 ++
 rtl/univ_shift_step.sv | 45 ++++
 rtl/univ_shift_seq.sv | 95 +++++++++
 tb/tb_univ_shift_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the universal shift register: opcodes and controller states.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_CPL = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100,
        OP_ROL = 3'b101,
        OP_ROR = 3'b110,
        OP_RSV = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/univ_shift_step.sv
// One-bit shift/rotate step: next register value and the bit that leaves it.
module univ_shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] d_next,
    output logic             bit_out
);

    always_comb begin
        d_next  = d;
        bit_out = 1'b0;
        case (op)
            OP_SLL: begin
                d_next  = {d[WIDTH-2:0], ser_in};
                bit_out = d[WIDTH-1];
            end
            OP_SRL: begin
                d_next  = {ser_in, d[WIDTH-1:1]};
                bit_out = d[0];
            end
            OP_SRA: begin
                d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            OP_ROL: begin
                d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
                bit_out = d[WIDTH-1];
            end
            OP_ROR: begin
                d_next  = {d[0], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            default: begin
                d_next  = d;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_seq.sv
// Sequential universal shift register: load, complement and multi-cycle
// shifts/rotates, one bit position per clock, framed by start/busy/done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; load/start accepted
// RUN     | stepping the latched op, cnt steps remaining; inputs ignored
// DONE    | done pulse cycle; load/start accepted back-to-back
module univ_shift_seq
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             ser_in,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state;
    op_e              op_q;
    logic [AMT_W-1:0] cnt;
    op_e              op_in;
    logic [WIDTH-1:0] step_d;
    logic             step_bit;

    assign op_in = op_e'(op);

    univ_shift_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .d       (dout),
        .ser_in  (ser_in),
        .d_next  (step_d),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt     <= '0;
            dout    <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    dout    <= step_d;
                    ser_out <= step_bit;
                    cnt     <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // load takes priority; a start in the same cycle is dropped
                    if (load) begin
                        dout  <= din;
                        state <= ST_IDLE;
                    end else if (start) begin
                        if (op_in == OP_CPL) begin
                            dout  <= ~dout;
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (is_shift(op_in) && (amt != '0)) begin
                            op_q  <= op_in;
                            cnt   <= amt;
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_seq.sv
// Scoreboard bench for univ_shift_seq (WIDTH=8) with a whole-operation reference model.
module tb_univ_shift_seq;

    localparam int W = 8;
    localparam logic [2:0] OP_NOP = 3'd0, OP_CPL = 3'd1, OP_SLL = 3'd2, OP_SRL = 3'd3,
                           OP_SRA = 3'd4, OP_ROL = 3'd5, OP_ROR = 3'd6;

    logic         clk = 1'b0;
    logic         reset, load, start, ser_in;
    logic [W-1:0] din;
    logic [2:0]   op, amt;
    logic [W-1:0] dout;
    logic         ser_out, busy, done;

    univ_shift_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (din),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .ser_in  (ser_in),
        .dout    (dout),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         so;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_d;
    logic         m_so;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of a whole operation computed in one go from the op definition.
    function automatic void model_op(input logic [2:0] o, input int n, input logic si);
        logic [W-1:0]        fill;
        logic signed [W-1:0] s;
        if (o == OP_CPL) begin
            m_d = ~m_d;
            return;
        end
        if (n == 0) return;
        case (o)
            OP_SLL: begin
                m_so = m_d[W-n];
                fill = si ? ~({W{1'b1}} << n) : '0;
                m_d  = (m_d << n) | fill;
            end
            OP_SRL: begin
                m_so = m_d[n-1];
                fill = si ? ~({W{1'b1}} >> n) : '0;
                m_d  = (m_d >> n) | fill;
            end
            OP_SRA: begin
                m_so = m_d[n-1];
                s    = m_d;
                m_d  = s >>> n;
            end
            OP_ROL: begin
                m_so = m_d[W-n];
                m_d  = (m_d << n) | (m_d >> (W - n));
            end
            OP_ROR: begin
                m_so = m_d[n-1];
                m_d  = (m_d >> n) | (m_d << (W - n));
            end
            default: ;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("dout", 32'(dout), 32'(e.d));
                check("ser_out", 32'(ser_out), 32'(e.so));
            end
        end
    end

    // All drive tasks are entered and left 1 time unit after a rising edge.
    task automatic do_load(input logic [W-1:0] v, input bit with_start);
        exp_t dummy;
        load  = 1'b1;
        din   = v;
        start = with_start;
        op    = 3'($urandom);
        amt   = 3'($urandom);
        @(posedge clk); #1;
        load  = 1'b0;
        start = 1'b0;
        m_d   = v;
        check("load_dout", 32'(dout), 32'(v));
        check("load_busy", 32'(busy), 32'd0);
        dummy.cyc = 0;
    endtask

    task automatic run_op(input logic [2:0] o, input int n, input logic si, input bit noise);
        exp_t e;
        bit   multi;
        multi  = (o inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR}) && (n > 0);
        op     = o;
        amt    = 3'(n);
        ser_in = si;
        start  = 1'b1;
        load   = 1'b0;
        model_op(o, n, si);
        e.d   = m_d;
        e.so  = m_so;
        e.cyc = cyc + (multi ? n + 1 : 1);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (multi) begin
            for (int k = 0; k < n; k++) begin
                check("busy_run", 32'(busy), 32'd1);
                if (noise) begin
                    start = 1'b1;
                    load  = 1'($urandom);
                    din   = 8'($urandom);
                    op    = 3'($urandom);
                    amt   = 3'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        load  = 1'b0;
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_run();
        do_load(8'hE7, 1'b0);
        op     = OP_SLL;
        amt    = 3'd5;
        ser_in = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_d   = '0;
        m_so  = 1'b0;
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("abort_busy_later", 32'(busy), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'($urandom);
        start  = 1'($urandom);
        din    = 8'($urandom);
        op     = 3'($urandom);
        amt    = 3'($urandom);
        ser_in = 1'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
            load  = 1'($urandom);
            start = 1'($urandom);
            din   = 8'($urandom);
            op    = 3'($urandom);
        end
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        m_d   = '0;
        m_so  = 1'b0;
        @(posedge clk); #1;

        do_load(8'hB4, 1'b0); run_op(OP_SLL, 3, 1'b0, 1'b0);
        do_load(8'h96, 1'b0); run_op(OP_SRA, 2, 1'b0, 1'b0);
        do_load(8'h01, 1'b0); run_op(OP_SRL, 7, 1'b1, 1'b0);
        do_load(8'h81, 1'b0); run_op(OP_ROR, 1, 1'b0, 1'b0);
        do_load(8'h81, 1'b0); run_op(OP_ROL, 4, 1'b0, 1'b0);
        do_load(8'h5A, 1'b0); run_op(OP_CPL, 0, 1'b0, 1'b0);
        run_op(OP_SRL, 0, 1'b1, 1'b0);
        run_op(OP_NOP, 5, 1'b0, 1'b0);
        run_op(3'd7, 3, 1'b1, 1'b0);

        do_load(8'h3C, 1'b0); run_op(OP_ROL, 5, 1'b0, 1'b1);
        run_op(OP_SRA, 6, 1'b0, 1'b1);
        do_load(8'hC3, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_mid_run();

        repeat (120) begin
            if ($urandom_range(0, 3) == 0)
                do_load(8'($urandom), 1'($urandom));
            else
                run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom),
                       $urandom_range(0, 3) == 0);
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pending_ops", 32'(sb.size()), 32'd0);
        check("final_dout", 32'(dout), 32'(m_d));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
